// File: rtl/debug_tap_fifo.sv
// rtl/debug_tap_fifo.sv - in-band configured debug tap: DUT pass-through or debug-signal capture FIFO
// Optional drop tag insertion is enabled by defining DEBUG_TAP_DROP_TAG_EN.
module debug_tap_fifo #(
  parameter int DATA_W    = 32,
  parameter int N_SIGNALS = 32,
  parameter int N_COND    = 24,
  parameter int DEPTH     = 16
) (
  input  logic                        clock,
  input  logic                        reset,
  input  logic [DATA_W-1:0]           in_data,
  input  logic                        in_valid,
  output logic                        upstream_stall,
  output logic [DATA_W-1:0]           out_data,
  output logic                        out_valid,
  input  logic                        downstream_stall,
  output logic [DATA_W-1:0]           dut_in_data,
  output logic                        dut_in_valid,
  input  logic                        dut_upstream_stall,
  input  logic [DATA_W-1:0]           dut_out_data,
  input  logic                        dut_out_valid,
  output logic                        dut_downstream_stall,
  input  logic [N_SIGNALS*DATA_W-1:0] debug_signals,
  input  logic [N_COND-1:0]           debug_conditions
);
  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;

  typedef enum logic [1:0] {CFG0, CFG1, RUN, DONE} state_t;
  state_t state, state_nx;

  logic [7:0]        select;
  logic [1:0]        mode;
  logic [N_COND-1:0] mask;
  logic              armed;
  logic [CW-1:0]     shot_cnt;
  logic [DATA_W-1:0] mem [DEPTH];
  logic [AW-1:0]     wr_ptr, rd_ptr, rd_next;
  logic [CW-1:0]     count, remain;

  logic              running, pass, hit, want, space, push, pop, sample_push;
  logic [DATA_W-1:0] sample, push_data;

`ifdef DEBUG_TAP_DROP_TAG_EN
  localparam int DW = DATA_W - 16;
  logic [DW-1:0] drop_cnt, drop_nx;
`endif

  always_comb begin
    sample = '0;
    for (int i = 0; i < N_SIGNALS; i++)
      if (int'(select) == i) sample = debug_signals[i*DATA_W +: DATA_W];
  end

  always_comb begin
    running     = (state == RUN) || (state == DONE);
    pass        = (mode == 2'd0) || (mode == 2'd3);
    hit         = |(mask & debug_conditions);
    want        = 1'b0;
    if (state == RUN && !pass)
      want = (mode == 2'd2) ? (armed | hit) : hit;
    // Count includes the word held in the output register, so a host pop frees a slot.
    pop         = !pass && out_valid && !downstream_stall;
    space       = (count != CW'(DEPTH)) || pop;
    push_data   = sample;
    push        = want && space;
    sample_push = push;
`ifdef DEBUG_TAP_DROP_TAG_EN
    drop_nx = drop_cnt;
    if (state == RUN && !pass && drop_cnt != '0 && space) begin
      push        = 1'b1;
      sample_push = 1'b0;
      push_data   = {16'hDEAD, drop_cnt};
      drop_nx     = want ? DW'(1) : '0;
    end else if (want && !space && drop_cnt != '1) begin
      drop_nx = drop_cnt + 1'b1;
    end
`else
    push = want && space;
`endif
    remain               = count - CW'(pop);
    rd_next              = rd_ptr + AW'(pop);
    upstream_stall       = running && dut_upstream_stall;
    dut_in_data          = in_data;
    dut_in_valid         = running && in_valid;
    dut_downstream_stall = running && pass && downstream_stall;
  end

  always_comb begin
    state_nx = state;
    case (state)
      CFG0:    if (in_valid) state_nx = CFG1;
      CFG1:    if (in_valid) state_nx = RUN;
      RUN:     if (mode == 2'd2 && sample_push && shot_cnt == CW'(DEPTH-1)) state_nx = DONE;
      default: state_nx = state;
    endcase
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) state <= CFG0;
    else       state <= state_nx;
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      select    <= '0;
      mode      <= '0;
      mask      <= '0;
      armed     <= 1'b0;
      shot_cnt  <= '0;
      wr_ptr    <= '0;
      rd_ptr    <= '0;
      count     <= '0;
      out_valid <= 1'b0;
      out_data  <= '0;
    end else begin
      if (state == CFG0 && in_valid) begin
        select <= in_data[7:0];
        mode   <= in_data[9:8];
      end
      if (state == CFG1 && in_valid) mask <= in_data[N_COND-1:0];
      if (state == RUN && mode == 2'd2 && hit) armed <= 1'b1;
      if (sample_push && mode == 2'd2) shot_cnt <= shot_cnt + 1'b1;
      if (push) wr_ptr <= wr_ptr + 1'b1;
      rd_ptr <= rd_next;
      count  <= remain + CW'(push);
      // Output register only moves when the host is not stalling.
      if (!downstream_stall) begin
        if (pass) begin
          out_valid <= running && dut_out_valid;
          out_data  <= dut_out_data;
        end else begin
          out_valid <= (remain != '0);
          if (remain != '0) out_data <= mem[rd_next];
        end
      end
    end
  end

  always_ff @(posedge clock) begin
    if (push) mem[wr_ptr] <= push_data;
  end

`ifdef DEBUG_TAP_DROP_TAG_EN
  always_ff @(posedge clock or posedge reset) begin
    if (reset) drop_cnt <= '0;
    else       drop_cnt <= drop_nx;
  end
`endif
endmodule

// File: tb/tb_debug_tap_fifo.sv
// tb/tb_debug_tap_fifo.sv - self-checking bench for debug_tap_fifo with a queue reference model
module tb_debug_tap_fifo;
  localparam int DATA_W    = 32;
  localparam int N_SIGNALS = 32;
  localparam int N_COND    = 24;
  localparam int DEPTH     = 4;

  logic                        clock = 1'b0;
  logic                        reset;
  logic [DATA_W-1:0]           in_data;
  logic                        in_valid;
  logic                        upstream_stall;
  logic [DATA_W-1:0]           out_data;
  logic                        out_valid;
  logic                        downstream_stall;
  logic [DATA_W-1:0]           dut_in_data;
  logic                        dut_in_valid;
  logic                        dut_upstream_stall;
  logic [DATA_W-1:0]           dut_out_data;
  logic                        dut_out_valid;
  logic                        dut_downstream_stall;
  logic [N_SIGNALS*DATA_W-1:0] debug_signals;
  logic [N_COND-1:0]           debug_conditions;

  int n_checks = 0;
  int n_fail   = 0;

  always #5 clock = ~clock;

  debug_tap_fifo #(.DATA_W(DATA_W), .N_SIGNALS(N_SIGNALS), .N_COND(N_COND), .DEPTH(DEPTH)) dut (
    .clock(clock), .reset(reset),
    .in_data(in_data), .in_valid(in_valid), .upstream_stall(upstream_stall),
    .out_data(out_data), .out_valid(out_valid), .downstream_stall(downstream_stall),
    .dut_in_data(dut_in_data), .dut_in_valid(dut_in_valid), .dut_upstream_stall(dut_upstream_stall),
    .dut_out_data(dut_out_data), .dut_out_valid(dut_out_valid), .dut_downstream_stall(dut_downstream_stall),
    .debug_signals(debug_signals), .debug_conditions(debug_conditions)
  );

  function automatic logic [DATA_W-1:0] sel_sample(input int sel);
    if (sel >= N_SIGNALS) return '0;
    return debug_signals[sel*DATA_W +: DATA_W];
  endfunction

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  task automatic idle_inputs();
    in_valid = 1'b0; in_data = '0; downstream_stall = 1'b0; dut_upstream_stall = 1'b0;
    dut_out_valid = 1'b0; dut_out_data = '0; debug_conditions = '0;
  endtask

  task automatic do_reset();
    idle_inputs();
    reset = 1'b1;
    tick(); tick();
    reset = 1'b0;
    tick();
  endtask

  task automatic configure(input logic [DATA_W-1:0] w0, input logic [DATA_W-1:0] w1);
    in_valid = 1'b1; in_data = w0; #1;
    n_checks++;
    if ({dut_in_valid, upstream_stall} !== 2'b00) begin
      n_fail++; $display("FAIL cfg0_not_forwarded dut_in_valid/upstream_stall=%b required 00", {dut_in_valid, upstream_stall});
    end
    tick();
    in_data = w1; #1;
    n_checks++;
    if ({dut_in_valid, upstream_stall} !== 2'b00) begin
      n_fail++; $display("FAIL cfg1_not_forwarded dut_in_valid/upstream_stall=%b required 00", {dut_in_valid, upstream_stall});
    end
    tick();
    in_valid = 1'b0; in_data = '0;
  endtask

  task automatic test_reset();
    idle_inputs();
    reset = 1'b1; in_valid = 1'b1; in_data = 32'h3FF; downstream_stall = 1'b1; dut_out_valid = 1'b1;
    tick();
    n_checks++;
    if ({out_valid, out_data} !== '0) begin
      n_fail++; $display("FAIL reset_out out_valid=%b out_data=%h required 0/0", out_valid, out_data);
    end
    n_checks++;
    if ({dut_in_valid, dut_downstream_stall, upstream_stall} !== 3'b000) begin
      n_fail++; $display("FAIL reset_dut_side got %b required 000", {dut_in_valid, dut_downstream_stall, upstream_stall});
    end
    reset = 1'b0; idle_inputs();
    tick();
  endtask

  task automatic test_pass();
    logic exp_v; logic [DATA_W-1:0] exp_d, d; logic st, v;
    do_reset();
    configure(32'h0000_0005, 32'h0000_0000);
    in_valid = 1'b1; in_data = 32'hCAFE_0001; dut_upstream_stall = 1'b1; #1;
    n_checks++;
    if ({dut_in_valid, dut_in_data, upstream_stall} !== {1'b1, 32'hCAFE_0001, 1'b1}) begin
      n_fail++; $display("FAIL pass_forward got %b/%h/%b required 1/cafe0001/1", dut_in_valid, dut_in_data, upstream_stall);
    end
    in_valid = 1'b0; dut_upstream_stall = 1'b0;
    dut_out_valid = 1'b1; dut_out_data = 32'h11; #1;
    n_checks++;
    if (out_valid !== 1'b0) begin n_fail++; $display("FAIL pass_not_early out_valid=%b required 0", out_valid); end
    tick();
    n_checks++;
    if ({out_valid, out_data} !== {1'b1, 32'h11}) begin
      n_fail++; $display("FAIL pass_word0 got %b/%h required 1/00000011", out_valid, out_data);
    end
    dut_out_data = 32'h22;
    tick();
    n_checks++;
    if ({out_valid, out_data} !== {1'b1, 32'h22}) begin
      n_fail++; $display("FAIL pass_word1 got %b/%h required 1/00000022", out_valid, out_data);
    end
    exp_v = 1'b1; exp_d = 32'h22;
    for (int c = 0; c < 30; c++) begin
      st = ($urandom_range(0, 2) == 0); v = 1'(($urandom));  d = $urandom;
      downstream_stall = st; dut_out_valid = v; dut_out_data = d; #1;
      n_checks++;
      if (dut_downstream_stall !== st) begin
        n_fail++; $display("FAIL pass_stall_prop cycle %0d got %b required %b", c, dut_downstream_stall, st);
      end
      tick();
      if (!st) begin exp_v = v; exp_d = d; end
      n_checks++;
      if (out_valid !== exp_v || (exp_v && out_data !== exp_d)) begin
        n_fail++; $display("FAIL pass_rand cycle %0d got %b/%h required %b/%h", c, out_valid, out_data, exp_v, exp_d);
      end
    end
    idle_inputs();
  endtask

  task automatic test_stream_order();
    logic [DATA_W-1:0] vals[3];
    vals[0] = 32'hA; vals[1] = 32'hB; vals[2] = 32'hC;
    do_reset();
    configure(32'h0000_0103, 32'h0000_0001);
    downstream_stall = 1'b1; #1;
    n_checks++;
    if (dut_downstream_stall !== 1'b0) begin
      n_fail++; $display("FAIL stream_dut_stall got %b required 0", dut_downstream_stall);
    end
    downstream_stall = 1'b0;
    for (int i = 0; i < 3; i++) begin
      debug_signals[3*DATA_W +: DATA_W] = vals[i]; debug_conditions = 24'h1;
      tick();
      n_checks++;
      if (i == 0 && out_valid !== 1'b0) begin
        n_fail++; $display("FAIL stream_latency_early out_valid=%b required 0", out_valid);
      end else if (i > 0 && {out_valid, out_data} !== {1'b1, vals[i-1]}) begin
        n_fail++; $display("FAIL stream_order word %0d got %b/%h required 1/%h", i - 1, out_valid, out_data, vals[i-1]);
      end
    end
    debug_conditions = '0;
    tick();
    n_checks++;
    if ({out_valid, out_data} !== {1'b1, vals[2]}) begin
      n_fail++; $display("FAIL stream_order word 2 got %b/%h required 1/%h", out_valid, out_data, vals[2]);
    end
    tick();
    n_checks++;
    if (out_valid !== 1'b0) begin n_fail++; $display("FAIL stream_empty out_valid=%b required 0", out_valid); end
  endtask

  task automatic test_overflow();
    logic [DATA_W-1:0] exp[$]; logic [DATA_W-1:0] got[$];
    do_reset();
    configure(32'h0000_0103, 32'h0000_0001);
    downstream_stall = 1'b1;
    for (int i = 1; i <= 6; i++) begin
      debug_signals[3*DATA_W +: DATA_W] = DATA_W'(i); debug_conditions = 24'h1;
      if (i <= DEPTH) exp.push_back(DATA_W'(i));
      tick();
    end
`ifdef DEBUG_TAP_DROP_TAG_EN
    exp.push_back(32'hDEAD_0002);
`endif
    debug_conditions = '0;
    tick();
    n_checks++;
    if (out_valid !== 1'b0) begin n_fail++; $display("FAIL overflow_hold out_valid=%b required 0", out_valid); end
    downstream_stall = 1'b0;
    for (int c = 0; c < 14; c++) begin
      if (out_valid) got.push_back(out_data);
      tick();
    end
    n_checks++;
    if (got.size() != exp.size()) begin
      n_fail++; $display("FAIL overflow_count got %0d words required %0d", got.size(), exp.size());
    end
    for (int i = 0; i < got.size() && i < exp.size(); i++) begin
      n_checks++;
      if (got[i] !== exp[i]) begin n_fail++; $display("FAIL overflow_word %0d got %h required %h", i, got[i], exp[i]); end
    end
  endtask

  task automatic test_oneshot();
    logic [DATA_W-1:0] exp[$]; logic [DATA_W-1:0] got[$]; logic [DATA_W-1:0] v;
    do_reset();
    configure(32'h0000_0205, 32'h0000_0004);
    for (int c = 0; c < 22; c++) begin
      if (out_valid) got.push_back(out_data);
      v = $urandom;
      debug_signals[5*DATA_W +: DATA_W] = v;
      debug_conditions = (c == 3 || c >= 12) ? 24'h4 : 24'hFF_FFFB;
      if (c >= 3 && c < 3 + DEPTH) exp.push_back(v);
      tick();
    end
    debug_conditions = '0;
    n_checks++;
    if (got.size() != DEPTH) begin n_fail++; $display("FAIL oneshot_count got %0d words required %0d", got.size(), DEPTH); end
    for (int i = 0; i < got.size() && i < exp.size(); i++) begin
      n_checks++;
      if (got[i] !== exp[i]) begin n_fail++; $display("FAIL oneshot_word %0d got %h required %h", i, got[i], exp[i]); end
    end
  endtask

  task automatic test_back_to_back();
    logic [DATA_W-1:0] exp[$]; logic [DATA_W-1:0] got[$]; logic [DATA_W-1:0] v; int valid_cycles;
    do_reset();
    configure(32'h0000_0109, 32'h0000_0010);
    downstream_stall = 1'b1;
    for (int i = 0; i < DEPTH; i++) begin
      v = $urandom; debug_signals[9*DATA_W +: DATA_W] = v; debug_conditions = 24'h10; exp.push_back(v);
      tick();
    end
    debug_conditions = '0; downstream_stall = 1'b0;
    tick();
    valid_cycles = 0;
    for (int i = 0; i < 12; i++) begin
      if (out_valid) begin got.push_back(out_data); valid_cycles++; end
      v = $urandom; debug_signals[9*DATA_W +: DATA_W] = v; debug_conditions = 24'h10; exp.push_back(v);
      tick();
    end
    debug_conditions = '0;
    for (int i = 0; i < 12; i++) begin
      if (out_valid) got.push_back(out_data);
      tick();
    end
    n_checks++;
    if (valid_cycles != 12) begin n_fail++; $display("FAIL b2b_full_flow valid cycles %0d required 12", valid_cycles); end
    n_checks++;
    if (got.size() != exp.size()) begin n_fail++; $display("FAIL b2b_count got %0d words required %0d", got.size(), exp.size()); end
    for (int i = 0; i < got.size() && i < exp.size(); i++) begin
      n_checks++;
      if (got[i] !== exp[i]) begin n_fail++; $display("FAIL b2b_word %0d got %h required %h", i, got[i], exp[i]); end
    end
  endtask

  task automatic test_random_stream();
    logic [DATA_W-1:0] q[$]; logic [N_COND-1:0] msk; logic [DATA_W-1:0] od;
    logic ov, pop, hit; int sel; int drops;
    for (int r = 0; r < 4; r++) begin
      do_reset();
      case (r)
        0: sel = 7;
        1: sel = 40;
        default: sel = $urandom_range(0, N_SIGNALS - 1);
      endcase
      msk = (r == 0) ? '0 : (N_COND'($urandom) | N_COND'(1));
      configure(32'h100 | DATA_W'(sel), DATA_W'(msk));
      q.delete(); drops = 0;
      for (int c = 0; c < 90; c++) begin
        ov = out_valid; od = out_data;
        if (ov) begin
          n_checks++;
          if (q.size() == 0) begin
            n_fail++; $display("FAIL rand_spurious round %0d cycle %0d out_data=%h required no word", r, c, od);
          end else if (od !== q[0]) begin
            n_fail++; $display("FAIL rand_data round %0d cycle %0d got %h required %h", r, c, od, q[0]);
          end
        end
        downstream_stall = (c >= 60) ? 1'b0 : ($urandom_range(0, (r % 2 == 1) ? 1 : 3) == 0);
        debug_conditions = (c < 60 && $urandom_range(0, 1) == 1) ? N_COND'($urandom) : '0;
        for (int i = 0; i < N_SIGNALS; i++) debug_signals[i*DATA_W +: DATA_W] = $urandom;
        pop = ov && !downstream_stall;
        hit = |(msk & debug_conditions);
        if (pop && q.size() > 0) q.delete(0);
`ifdef DEBUG_TAP_DROP_TAG_EN
        if (drops > 0 && q.size() < DEPTH) begin
          q.push_back({16'hDEAD, 16'(drops)});
          drops = hit ? 1 : 0;
        end else if (hit) begin
          if (q.size() < DEPTH) q.push_back(sel_sample(sel));
          else if (drops < 32'hFFFF) drops++;
        end
`else
        if (hit && q.size() < DEPTH) q.push_back(sel_sample(sel));
`endif
        tick();
      end
      n_checks++;
      if (q.size() != 0 || out_valid !== 1'b0) begin
        n_fail++; $display("FAIL rand_drain round %0d model words left %0d out_valid=%b required 0/0", r, q.size(), out_valid);
      end
    end
    idle_inputs();
  endtask

  task automatic test_reset_mid_drain();
    do_reset();
    configure(32'h0000_0103, 32'h0000_0001);
    downstream_stall = 1'b1;
    for (int i = 0; i < 3; i++) begin
      debug_signals[3*DATA_W +: DATA_W] = DATA_W'(32'h50 + i); debug_conditions = 24'h1;
      tick();
    end
    debug_conditions = '0; downstream_stall = 1'b0;
    tick(); tick();
    n_checks++;
    if (out_valid !== 1'b1) begin n_fail++; $display("FAIL drain_active out_valid=%b required 1", out_valid); end
    #2 reset = 1'b1;
    #1;
    n_checks++;
    if (out_valid !== 1'b0) begin n_fail++; $display("FAIL async_reset out_valid=%b required 0 before edge", out_valid); end
    #2 reset = 1'b0;
    tick();
    n_checks++;
    if (out_valid !== 1'b0) begin n_fail++; $display("FAIL reset_lost_samples out_valid=%b required 0", out_valid); end
    configure(32'h0000_0000, 32'h0000_0000);
    in_valid = 1'b1; in_data = 32'h1234_5678; #1;
    n_checks++;
    if ({dut_in_valid, dut_in_data} !== {1'b1, 32'h1234_5678}) begin
      n_fail++; $display("FAIL reconfig_run got %b/%h required 1/12345678", dut_in_valid, dut_in_data);
    end
    in_valid = 1'b0; dut_out_valid = 1'b1; dut_out_data = 32'h77;
    tick();
    n_checks++;
    if ({out_valid, out_data} !== {1'b1, 32'h77}) begin
      n_fail++; $display("FAIL reconfig_pass got %b/%h required 1/00000077", out_valid, out_data);
    end
    idle_inputs();
  endtask

  initial begin
    reset = 1'b1;
    debug_signals = '0;
    idle_inputs();
    test_reset();
    test_pass();
    test_stream_order();
    test_overflow();
    test_oneshot();
    test_back_to_back();
    test_random_stream();
    test_reset_mid_drain();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule
